fetch_stage: RTL

//  Instruction-fetch stage directly upstream of the decode stage. Holds the PC, issues in-order

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the front end.
package pipeline_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // One buffered fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Word-align an address by clearing the byte-offset bits.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetch_entry_t with flush.
// Head entry is read straight from the storage registers.
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  // Entry storage write port.
  // NOTE: storage is deliberately not reset; the count guards every read so stale words are never used.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding decode.
// Issues in-order word fetches under a credit limit of FIFO_DEPTH, buffers
// returned words with their PC and hands {ir, pc} to decode. A redirect
// flushes the buffer and discards every fetch still in flight.
// Optional feature macro: FETCH_BYPASS_EN (response shown to decode in the
// same cycle when the buffer is empty).
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_ir,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW:0]   CREDITS = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_next;
  logic [CW-1:0]   drop;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] redirect_target;

  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_valid;

  logic            req_fire;
  logic            rsp_take;
  logic            rsp_keep;
  logic            bypass_hit;

  assign redirect_target = word_align(redirect_pc);

  // Credits cover both buffered words and fetches still in flight, so a
  // returning word always has a slot. The request line stays quiet in reset.
  assign occupancy      = {1'b0, fifo_count} + {1'b0, inflight};
  assign imem_req_valid = rst_n && (occupancy < CREDITS) && !redirect_valid;
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is ignored; stale ones are dropped.
  assign rsp_take = imem_rsp_valid && (inflight != '0);
  assign rsp_keep = rsp_take && (drop == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = rsp_keep && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign fifo_valid  = !fifo_empty && !redirect_valid;
  assign id_valid    = fifo_valid || bypass_hit;
  assign fifo_pop    = fifo_valid && id_ready;
  assign fifo_push   = rsp_keep && !(bypass_hit && id_ready);
  assign push_entry  = '{ir: imem_rsp_data, pc: rsp_pc};
  assign id_pc_plus4 = id_pc + PC_STEP;

  // Decode view: buffer head, else the bypassed response, else a NOP at the next expected PC.
  // NOTE: every always_comb output gets a default on entry so no latch can be inferred.
  always_comb begin
    id_ir = INSTR_NOP;
    id_pc = rsp_pc;
    if (!fifo_empty) begin
      id_ir = fifo_head.ir;
      id_pc = fifo_head.pc;
    end else if (bypass_hit) begin
      id_ir = imem_rsp_data;
    end
  end

  // Outstanding-fetch count after this cycle's request and response.
  always_comb begin
    inflight_next = inflight;
    if (req_fire) inflight_next = inflight_next + CNT_ONE;
    if (rsp_take) inflight_next = inflight_next - CNT_ONE;
  end

  // Fetch/response PCs and the in-flight/drop counters; redirect wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        pc     <= redirect_target;
        rsp_pc <= redirect_target;
        drop   <= inflight_next;
      end else begin
        if (req_fire)                 pc     <= pc + PC_STEP;
        if (rsp_keep)                 rsp_pc <= rsp_pc + PC_STEP;
        if (rsp_take && drop != '0)   drop   <= drop - CNT_ONE;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Memory must never answer a fetch that was not issued.
  rsp_without_request : assert property (
    @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (inflight != '0));

endmodule
